order_msg_fifo: RTL

//  Ingress stage directly upstream of the parser/order-book top level.

---
 rtl/order_msg_fifo_if.sv | 36 +++
 rtl/order_msg_fifo.sv | 113 +++++++++++
 2 files changed

// File: rtl/order_msg_fifo_if.sv
// order_msg_fifo_if
//   Bundles the word-stream input and the record-queue output of
//   order_msg_fifo.
//   master : the upstream word source plus the downstream consumer.
//            It drives wr_valid/wr_data/wr_last/system_free.
//   slave  : the FIFO block itself.
//            It drives wr_ready/buffer_not_empty/ff_buffer/fill_level/err_count.
interface order_msg_fifo_if #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 10,
   parameter int DEPTH  = 8,
   parameter int ERR_W  = 16
);
   localparam int MSG_W = WORD_W * WORDS;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic              wr_valid;
   logic              wr_ready;
   logic [WORD_W-1:0] wr_data;
   logic              wr_last;
   logic              system_free;
   logic              buffer_not_empty;
   logic [MSG_W-1:0]  ff_buffer;
   logic [FW-1:0]     fill_level;
   logic [ERR_W-1:0]  err_count;

   modport master (
      output wr_valid, wr_data, wr_last, system_free,
      input  wr_ready, buffer_not_empty, ff_buffer, fill_level, err_count
   );

   modport slave (
      input  wr_valid, wr_data, wr_last, system_free,
      output wr_ready, buffer_not_empty, ff_buffer, fill_level, err_count
   );
endinterface

// File: rtl/order_msg_fifo.sv
// order_msg_fifo
//   Assembles WORDS-word order messages into MSG_W-bit records.
//   The first word lands in the most significant slot.
//   Completed records are queued in a DEPTH-entry first-word-fall-through FIFO.
//   Malformed messages are dropped and counted:
//     - short: wr_last arrives before word WORDS-1.
//     - long:  no wr_last on word WORDS-1. The rest of the message is
//       discarded up to and including its wr_last.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : order_msg_fifo_if.slave, carrying
//           - the word stream (wr_valid/wr_ready/wr_data/wr_last)
//           - the pop request (system_free)
//           - the head record (buffer_not_empty/ff_buffer)
//           - the status outputs (fill_level/err_count)
module order_msg_fifo #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 10,
   parameter int DEPTH  = 8,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   order_msg_fifo_if.slave  bus
);
   localparam int MSG_W = WORD_W * WORDS;
   localparam int CW    = $clog2(WORDS);
   localparam int PW    = $clog2(DEPTH);
   localparam int FW    = PW + 1;

   typedef enum logic {COLLECT, DISCARD} state_t;

   state_t            state_q;
   logic [CW-1:0]     word_cnt_q;
   logic [MSG_W-1:0]  asm_q;
   logic [MSG_W-1:0]  mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [FW-1:0]     fill_q;
   logic [ERR_W-1:0]  err_q;

   logic             last_slot, full, not_empty, in_collect;
   logic             accept, push, pop, err_inc;
   logic [MSG_W-1:0] push_rec;

   assign in_collect = (state_q == COLLECT);
   assign last_slot  = (word_cnt_q == CW'(WORDS - 1));
   assign full       = (fill_q == FW'(DEPTH));
   assign not_empty  = (fill_q != '0);

   // Stall only the word that would complete a record into a full queue.
   // A same-cycle pop is deliberately not considered, which keeps
   // system_free off the wr_ready path.
   assign bus.wr_ready = !in_collect || !(last_slot && full);

   assign accept  = bus.wr_valid && bus.wr_ready;
   assign push    = accept && in_collect && last_slot && bus.wr_last;
   assign pop     = not_empty && bus.system_free;

   // Short and long messages are exactly the cases where wr_last
   // disagrees with the slot position.
   assign err_inc = accept && in_collect && (last_slot ^ bus.wr_last);

   // The final word bypasses the assembly register straight into the queue.
   assign push_rec = {asm_q[MSG_W-1:WORD_W], bus.wr_data};

   assign bus.buffer_not_empty = not_empty;
   assign bus.ff_buffer        = not_empty ? mem_q[rd_ptr_q] : '0;
   assign bus.fill_level       = fill_q;
   assign bus.err_count        = err_q;

   // Storage has no reset; stale entries are never visible because
   // ff_buffer is gated by fill_level.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_rec;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= COLLECT;
         word_cnt_q <= '0;
         asm_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         err_q      <= '0;
      end else begin
         if (accept) begin
            if (in_collect) begin
               if (!bus.wr_last && !last_slot) begin
                  for (int k = 0; k < WORDS - 1; k++)
                     if (word_cnt_q == CW'(k))
                        asm_q[MSG_W-1-k*WORD_W -: WORD_W] <= bus.wr_data;
                  word_cnt_q <= word_cnt_q + CW'(1);
               end else begin
                  word_cnt_q <= '0;
                  if (!bus.wr_last) state_q <= DISCARD;
               end
            end else if (bus.wr_last) begin
               state_q <= COLLECT;
            end
         end

         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

         if (push && !pop)      fill_q <= fill_q + FW'(1);
         else if (pop && !push) fill_q <= fill_q - FW'(1);

         if (err_inc && (err_q != '1)) err_q <= err_q + ERR_W'(1);
      end
   end
endmodule
